vtiming_gen: RTL and testbench
==============================

# vtiming_gen

Parametrised vertical timing generator for the VGA display path; it is the next-generation replacement for the fixed 640x480 vertical scan. It counts scan lines on the horizontal end-of-line strobe, walks an explicit ACTIVE/FRONT/SYNC/BACK phase machine with per-phase lengths set by parameters, and drives vertical sync with selectable polarity, an active-video flag, the line number and frame boundary pulses. It sits between the horizontal timing block and the pixel/object renderers (paddles, ball, score).

## Interface
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, front-porch lines
- V_SYNC, 2, sync-pulse lines
- V_BP, 33, back-porch lines
- CW, 10, line-counter width; must hold V_ACTIVE+V_FP+V_SYNC+V_BP-1
- SYNC_POL, 0, 0 = sync active-low, 1 = active-high
- FCW, 8, frame-counter width (only with VTIMING_FRAME_CNT_EN)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick_en  in  1  pixel-rate enable; all advancement is gated by it
- line_end  in  1  horizontal counter at last pixel of the line
- v_count  out  CW  current line, 0..TOTAL-1
- v_vid  out  1  high while in ACTIVE phase
- v_sync  out  1  sync, polarity per SYNC_POL
- frame_start  out  1  one-cycle pulse when v_count wraps to 0
- last_line  out  1  v_count == TOTAL-1
- frame_cnt  out  FCW  completed-frame count (only with VTIMING_FRAME_CNT_EN)

## Operation
- TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525); TOTAL-1 must fit in CW bits. Every phase length must be >= 1. Either violation is an elaboration error.
- adv = tick_en & line_end. No state changes on cycles without adv. line_end without tick_en is ignored.
- v_count: on adv, increments; at TOTAL-1 it wraps to 0. Unsigned arithmetic, CW bits, and it never exceeds TOTAL-1.
- Phase FSM states are ACTIVE, FRONT, SYNC, BACK. An internal phase line counter is loaded with phase length-1 on entry and decrements on adv. On adv with the phase counter at 0, the FSM moves ACTIVE->FRONT->SYNC->BACK->ACTIVE. The BACK->ACTIVE transition coincides exactly with the v_count wrap.
- v_vid = (state==ACTIVE). v_sync = (state==SYNC) XOR ~SYNC_POL, so with SYNC_POL=0 the line is low only in SYNC.
- With default parameters: v_vid is high on lines 0..479, and v_sync is asserted on lines 490..491 only.
- Reset values: v_count=0, state=ACTIVE with phase counter V_ACTIVE-1, v_vid=1, v_sync deasserted (1 for SYNC_POL=0), frame_start=0, last_line=0, frame_cnt=0.
- Reset mid-frame aborts the frame immediately and asynchronously. No frame_start pulse is issued for the aborted frame.

## Timing
- v_count, state, v_vid and v_sync are registered and update on the same clk edge as the adv that changes them, so they are mutually consistent every cycle.
- frame_start is registered. It is high for exactly one clk cycle, the first cycle with v_count==0 after a wrap. It is not asserted coming out of reset.
- last_line is a combinational decode of the registered v_count.
- Latency is 1 clk from the adv cycle to the new outputs.

## Configuration
- VTIMING_FRAME_CNT_EN defined: the frame_cnt port exists. It increments (mod 2^FCW) on the same edge that wraps v_count to 0, and it resets to 0.
- VTIMING_FRAME_CNT_EN undefined: the frame_cnt port and its register are absent. All other behaviour is identical.

## Structure
- Shared package vtiming_pkg holds:
  - the phase enum typedef (ACTIVE, FRONT, SYNC, BACK);
  - default constants for 640x480@60 (480/10/2/33);
  - a localparam function computing TOTAL.
- Single module; no sub-module is warranted. The phase counter and the FSM live in the same block.

## Test plan
- Reset then 525 adv strobes (defaults) -> v_count runs 0..524 then returns to 0; frame_start pulses once; last_line is high only at 524.
- Defaults, SYNC_POL=0 -> v_sync is low exactly on lines 490 and 491; v_vid is high exactly on lines 0..479.
- line_end held high with tick_en=0 for 100 cycles -> v_count, state and all outputs are unchanged.
- V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, SYNC_POL=1 -> TOTAL=8; v_sync is high only on line 5; v_vid is high on lines 0..3.
- Assert rst at line 300 mid-frame -> outputs immediately take their reset values; after release, counting restarts at 0 with no frame_start.
- With VTIMING_FRAME_CNT_EN and FCW=2, run 5 frames -> frame_cnt goes 1,2,3,0,1, each change coinciding with frame_start.

Source files
------------

// File: rtl/vtiming_pkg.sv
// Shared definitions for the vertical timing generator: phase encoding,
// 640x480@60 default line counts and the frame-length helper.
package vtiming_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int vtotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vtiming_gen.sv
// Vertical timing generator: line counter plus ACTIVE/FRONT/SYNC/BACK phase
// machine advanced by tick_en & line_end. Define VTIMING_FRAME_CNT_EN for frame_cnt.
module vtiming_gen
  import vtiming_pkg::*;
#(
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CW       = 10,
  parameter bit SYNC_POL = 1'b0
`ifdef VTIMING_FRAME_CNT_EN
  ,
  parameter int FCW      = 8
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_en,
  input  logic          line_end,
  output logic [CW-1:0] v_count,
  output logic          v_vid,
  output logic          v_sync,
  output logic          frame_start,
  output logic          last_line
`ifdef VTIMING_FRAME_CNT_EN
  ,
  output logic [FCW-1:0] frame_cnt
`endif
);

  localparam int TOTAL = vtotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_phase_len
    $error("vtiming_gen: every phase length must be at least 1");
  end
  if (CW < 1 || CW > 30 || (TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
    $error("vtiming_gen: TOTAL-1 does not fit in CW bits");
  end

  localparam logic [CW-1:0] LAST_LINE = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACTIVE_M1 = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] FP_M1     = CW'(V_FP - 1);
  localparam logic [CW-1:0] SYNC_M1   = CW'(V_SYNC - 1);
  localparam logic [CW-1:0] BP_M1     = CW'(V_BP - 1);

  // Sync level outside the SYNC phase, and inside it.
  localparam logic SYNC_IDLE = ~SYNC_POL;
  localparam logic SYNC_ON   = SYNC_POL;

  phase_t        state;
  logic [CW-1:0] ph_cnt;
  logic          adv;
  logic          wrap;

  assign adv       = tick_en & line_end;
  assign wrap      = (v_count == LAST_LINE);
  assign last_line = wrap;

  // Line counter, phase counter and FSM share one block so v_count, state,
  // v_vid and v_sync always change on the same edge and never disagree.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_count     <= '0;
      state       <= ACTIVE;
      ph_cnt      <= ACTIVE_M1;
      v_vid       <= 1'b1;
      v_sync      <= SYNC_IDLE;
      frame_start <= 1'b0;
    end else begin
      frame_start <= adv & wrap;
      if (adv) begin
        v_count <= wrap ? '0 : v_count + 1'b1;
        if (ph_cnt == '0) begin
          case (state)
            ACTIVE: begin
              state  <= FRONT;
              ph_cnt <= FP_M1;
              v_vid  <= 1'b0;
            end
            FRONT: begin
              state  <= SYNC;
              ph_cnt <= SYNC_M1;
              v_sync <= SYNC_ON;
            end
            SYNC: begin
              state  <= BACK;
              ph_cnt <= BP_M1;
              v_sync <= SYNC_IDLE;
            end
            BACK: begin
              // Lands on the same edge as the v_count wrap by construction.
              state  <= ACTIVE;
              ph_cnt <= ACTIVE_M1;
              v_vid  <= 1'b1;
            end
            default: begin
              state  <= ACTIVE;
              ph_cnt <= ACTIVE_M1;
              v_vid  <= 1'b1;
              v_sync <= SYNC_IDLE;
            end
          endcase
        end else begin
          ph_cnt <= ph_cnt - 1'b1;
        end
      end
    end
  end

`ifdef VTIMING_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (adv && wrap) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vtiming_gen.sv
// Scoreboard bench for vtiming_gen: a default 525-line instance and a tiny
// 8-line active-high-sync instance share one stimulus stream.
module tb_vtiming_gen;

  localparam int TOT_D = 525;
  localparam int TOT_S = 8;

  typedef struct {
    int vc;
    bit vid;
    bit sync;
    bit fs;
    bit last;
    int fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_en = 1'b0;
  logic line_end = 1'b0;

  logic [9:0] vc_d;
  logic       vid_d, sync_d, fs_d, last_d;
  logic [2:0] vc_s;
  logic       vid_s, sync_s, fs_s, last_s;
`ifdef VTIMING_FRAME_CNT_EN
  logic [7:0] fc_d;
  logic [1:0] fc_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_def[$];
  exp_t q_sml[$];

  int ld = 0, ls = 0, fcd = 0, fcs = 0;
  bit fsd = 0, fss = 0;

  always #5 clk = ~clk;

  vtiming_gen #(
    .CW(10)
`ifdef VTIMING_FRAME_CNT_EN
    , .FCW(8)
`endif
  ) u_def (
    .clk(clk), .rst(rst), .tick_en(tick_en), .line_end(line_end),
    .v_count(vc_d), .v_vid(vid_d), .v_sync(sync_d),
    .frame_start(fs_d), .last_line(last_d)
`ifdef VTIMING_FRAME_CNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  vtiming_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .CW(3), .SYNC_POL(1'b1)
`ifdef VTIMING_FRAME_CNT_EN
    , .FCW(2)
`endif
  ) u_sml (
    .clk(clk), .rst(rst), .tick_en(tick_en), .line_end(line_end),
    .v_count(vc_s), .v_vid(vid_s), .v_sync(sync_s),
    .frame_start(fs_s), .last_line(last_s)
`ifdef VTIMING_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Expected outputs derived from the line number and the phase boundaries.
  function automatic exp_t model(input int va, input int fp, input int s, input int bp,
                                 input bit pol, input int line, input bit fs, input int fc);
    exp_t e;
    int   t;
    t      = va + fp + s + bp;
    e.vc   = line;
    e.vid  = (line < va);
    e.sync = ((line >= va + fp) && (line < va + fp + s)) ? pol : !pol;
    e.fs   = fs;
    e.last = (line == t - 1);
    e.fc   = fc;
    return e;
  endfunction

  function automatic exp_t exp_def();
    return model(480, 10, 2, 33, 1'b0, ld, fsd, fcd);
  endfunction

  function automatic exp_t exp_sml();
    return model(4, 1, 1, 2, 1'b1, ls, fss, fcs);
  endfunction

  task automatic model_reset();
    ld = 0; ls = 0; fcd = 0; fcs = 0; fsd = 0; fss = 0;
  endtask

  // One clock of stimulus; the expected state after the edge goes to the scoreboard.
  task automatic step(input bit te, input bit le, input bit r);
    @(negedge clk);
    tick_en  = te;
    line_end = le;
    rst      = r;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (te && le) begin
      fsd = (ld == TOT_D - 1);
      ld  = fsd ? 0 : ld + 1;
      if (fsd) fcd = (fcd + 1) % 256;
      fss = (ls == TOT_S - 1);
      ls  = fss ? 0 : ls + 1;
      if (fss) fcs = (fcs + 1) % 4;
    end else begin
      fsd = 1'b0;
      fss = 1'b0;
    end
    q_def.push_back(exp_def());
    q_sml.push_back(exp_sml());
  endtask

  // Monitor: every cycle the DUTs present a line state; compare one entry each.
  always @(negedge clk) begin
    exp_t e;
    if (q_def.size() > 0) begin
      e = q_def.pop_front();
      check($sformatf("def.v_count@%0d", e.vc), int'(vc_d), e.vc);
      check($sformatf("def.v_vid@%0d", e.vc), int'(vid_d), int'(e.vid));
      check($sformatf("def.v_sync@%0d", e.vc), int'(sync_d), int'(e.sync));
      check($sformatf("def.frame_start@%0d", e.vc), int'(fs_d), int'(e.fs));
      check($sformatf("def.last_line@%0d", e.vc), int'(last_d), int'(e.last));
`ifdef VTIMING_FRAME_CNT_EN
      check($sformatf("def.frame_cnt@%0d", e.vc), int'(fc_d), e.fc);
`endif
    end
    if (q_sml.size() > 0) begin
      e = q_sml.pop_front();
      check($sformatf("sml.v_count@%0d", e.vc), int'(vc_s), e.vc);
      check($sformatf("sml.v_vid@%0d", e.vc), int'(vid_s), int'(e.vid));
      check($sformatf("sml.v_sync@%0d", e.vc), int'(sync_s), int'(e.sync));
      check($sformatf("sml.frame_start@%0d", e.vc), int'(fs_s), int'(e.fs));
      check($sformatf("sml.last_line@%0d", e.vc), int'(last_s), int'(e.last));
`ifdef VTIMING_FRAME_CNT_EN
      check($sformatf("sml.frame_cnt@%0d", e.vc), int'(fc_s), e.fc);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;

    // Reset held: advance requests are ignored.
    repeat (3) step(1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // line_end without tick_en, and tick_en without line_end: no movement.
    repeat (100) step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);

    // Just over one full default frame (many small frames), with idle gaps.
    for (int i = 0; i < 530; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i % 7 == 3) step(1'b0, 1'b1, 1'b0);
    end

    // Advance into the second frame up to line 300.
    guard = 0;
    while (ld != 300 && guard < 1000) begin
      step(1'b1, 1'b1, 1'b0);
      guard++;
    end
    check("reach_line_300", ld, 300);

    // Asynchronous reset mid-frame: outputs must drop before the next edge.
    #1 rst = 1'b1;
    model_reset();
    q_def[q_def.size() - 1] = exp_def();
    q_sml[q_sml.size() - 1] = exp_sml();
    repeat (2) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", q_def.size() + q_sml.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
